// File: rtl/ddr_cmd_pkg.sv
// ----------------------------------------------------------------------------
// ddr_cmd_pkg
// Shared definitions for the multi-rank DDR4 command decoder.
// Holds the decoded-command enum and its one-hot encoding, the command and
// address bit positions on the A bus, the per-bank request payload, and the
// burst-length helper.
// ----------------------------------------------------------------------------
package ddr_cmd_pkg;

    localparam int unsigned CMD_W = 19;

    // A16/A15/A14 carry RAS_n/CAS_n/WE_n when act_n is high
    localparam int unsigned RAS_BIT = 16;
    localparam int unsigned CAS_BIT = 15;
    localparam int unsigned WE_BIT  = 14;
    localparam int unsigned A10_BIT = 10;
    localparam int unsigned A12_BIT = 12;

    // Value is the bit position in the one-hot commands vector; 9..18 unused
    typedef enum logic [4:0] {
        CMD_ACT  = 5'd0,
        CMD_MRS  = 5'd1,
        CMD_REF  = 5'd2,
        CMD_PRE  = 5'd3,
        CMD_PREA = 5'd4,
        CMD_WR   = 5'd5,
        CMD_RD   = 5'd6,
        CMD_ZQC  = 5'd7,
        CMD_NOP  = 5'd8
    } cmd_e;

    // Per-bank request decoded from the shared bus
    typedef struct packed {
        logic act;
        logic pre;
        logic rw;
        logic wr;
        logic bc4;
    } bank_req_t;

    function automatic logic [CMD_W-1:0] cmd_onehot(input cmd_e c);
        return CMD_W'(1) << c;
    endfunction

    function automatic int unsigned blbits(input int unsigned bl);
        return $clog2(bl);
    endfunction

endpackage

// File: rtl/bank_burst_ctrl.sv
// ----------------------------------------------------------------------------
// bank_burst_ctrl
// State of one DDR4 bank: open row, burst column counter, direction and a
// three-state bank FSM (IDLE, ACTIVE, BURST).
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   cke          0 freezes all state
//   req_i        decoded request for this bank (act/pre/rw/wr/bc4)
//   addr_i       A bus (row on ACT, column in low bits on RD/WR)
//   row_o        open row
//   col_o        current burst column
//   wr_o         1 = write, 0 = read
//   burst_o      burst in progress
//   open_o       bank has an active row
//   illegal_c    combinational: ACT to open bank or RD/WR to idle bank
// ----------------------------------------------------------------------------
module bank_burst_ctrl
    import ddr_cmd_pkg::*;
#(
    parameter int unsigned ADDRWIDTH = 17,
    parameter int unsigned COLWIDTH  = 10,
    parameter int unsigned BL        = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cke,
    input  bank_req_t            req_i,
    input  logic [ADDRWIDTH-1:0] addr_i,
    output logic [ADDRWIDTH-1:0] row_o,
    output logic [COLWIDTH-1:0]  col_o,
    output logic                 wr_o,
    output logic                 burst_o,
    output logic                 open_o,
    output logic                 illegal_c
);

    localparam int unsigned BLBITS = blbits(BL);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_BURST  = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [ADDRWIDTH-1:0]   row_q, row_d;
    logic [COLWIDTH-1:0]    col_q, col_d;
    logic [BLBITS-1:0]      cnt_q, cnt_d;
    logic                   wr_q, wr_d;
    logic                   bc4_q, bc4_d;
    logic                   burst_q, burst_d;
    logic                   open_q, open_d;
    logic [COLWIDTH-1:0]    col_inc;
    logic [COLWIDTH-1:0]    wrap_mask;

    // Next-state: burst advance, then ACT/RD/WR, PRE last so it wins
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        cnt_d     = cnt_q;
        wr_d      = wr_q;
        bc4_d     = bc4_q;
        illegal_c = 1'b0;
        col_inc   = col_q + COLWIDTH'(1);
        // Column wraps inside the aligned burst block
        wrap_mask = bc4_q ? COLWIDTH'(3) : COLWIDTH'(BL - 1);

        if (cke) begin
            if (state_q == ST_BURST) begin
                if (cnt_q == '0) begin
                    state_d = ST_ACTIVE;
                end else begin
                    cnt_d = cnt_q - BLBITS'(1);
                    col_d = (col_q & ~wrap_mask) | (col_inc & wrap_mask);
                end
            end

            if (req_i.act) begin
                if (state_q == ST_IDLE) begin
                    row_d   = addr_i;
                    state_d = ST_ACTIVE;
                end else begin
                    illegal_c = 1'b1;
                end
            end

            if (req_i.rw) begin
                if (state_q == ST_IDLE) begin
                    illegal_c = 1'b1;
                end else begin
                    col_d   = addr_i[COLWIDTH-1:0];
                    wr_d    = req_i.wr;
                    bc4_d   = req_i.bc4;
                    cnt_d   = req_i.bc4 ? BLBITS'(3) : BLBITS'(BL - 1);
                    state_d = ST_BURST;
                end
            end

            if (req_i.pre) begin
                state_d = ST_IDLE;
                wr_d    = 1'b0;
            end
        end

        burst_d = (state_d == ST_BURST);
        open_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            bc4_q   <= 1'b0;
            burst_q <= 1'b0;
            open_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            bc4_q   <= bc4_d;
            burst_q <= burst_d;
            open_q  <= open_d;
        end
    end

    assign row_o   = row_q;
    assign col_o   = col_q;
    assign wr_o    = wr_q;
    assign burst_o = burst_q;
    assign open_o  = open_q;

endmodule

// File: rtl/cmd_decoder_mr.sv
// ----------------------------------------------------------------------------
// cmd_decoder_mr
// Multi-rank registered DDR4 command decoder. Decodes the command bus each
// cycle into one-hot commands and per-rank/bank row, column, direction and
// burst state, with one cycle of latency.
// Optional feature macro: BC4_OTF_EN (A12=0 on RD/WR selects burst chop 4).
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   cke                 0 = ignore bus and hold all state
//   cs_n[RANKS]         per-rank chip select, active low
//   act_n, bg, ba, A    command bus
//   RowId/ColId/rd_o_wr/Burst/BankOpen  per [rank][group][bank] state
//   commands            one-hot command decoded last cycle
//   illegal[RANKS]      one-cycle protocol-violation pulse per rank
// ----------------------------------------------------------------------------
module cmd_decoder_mr
    import ddr_cmd_pkg::*;
#(
    parameter int unsigned RANKS     = 2,
    parameter int unsigned ADDRWIDTH = 17,
    parameter int unsigned COLWIDTH  = 10,
    parameter int unsigned BGWIDTH   = 2,
    parameter int unsigned BAWIDTH   = 2,
    parameter int unsigned BL        = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cke,
    input  logic [RANKS-1:0]     cs_n,
    input  logic                 act_n,
    input  logic [BGWIDTH-1:0]   bg,
    input  logic [BAWIDTH-1:0]   ba,
    input  logic [ADDRWIDTH-1:0] A,
    output logic [ADDRWIDTH-1:0] RowId    [RANKS][2**BGWIDTH][2**BAWIDTH],
    output logic [COLWIDTH-1:0]  ColId    [RANKS][2**BGWIDTH][2**BAWIDTH],
    output logic                 rd_o_wr  [RANKS][2**BGWIDTH][2**BAWIDTH],
    output logic                 Burst    [RANKS][2**BGWIDTH][2**BAWIDTH],
    output logic                 BankOpen [RANKS][2**BGWIDTH][2**BAWIDTH],
    output logic [CMD_W-1:0]     commands,
    output logic [RANKS-1:0]     illegal
);

    localparam int unsigned BANKGROUPS    = 2**BGWIDTH;
    localparam int unsigned BANKSPERGROUP = 2**BAWIDTH;

    logic [RANKS-1:0] sel_c;
    logic             any_sel_c;
    logic [2:0]       code_c;
    cmd_e             cmd_c;
    logic [CMD_W-1:0] cmd_oh_c;
    logic [RANKS-1:0] ill_c;
    logic             bc4_c;
    logic             bank_ill_c [RANKS][BANKGROUPS][BANKSPERGROUP];

`ifdef BC4_OTF_EN
    assign bc4_c = ~A[A12_BIT];
`else
    assign bc4_c = 1'b0;
`endif

    assign sel_c     = ~cs_n & {RANKS{cke}};
    assign any_sel_c = |sel_c;
    assign code_c    = {A[RAS_BIT], A[CAS_BIT], A[WE_BIT]};

    // Shared bus decode; unassigned code 011 is treated as NOP
    always_comb begin
        cmd_c = CMD_NOP;
        if (!act_n) begin
            cmd_c = CMD_ACT;
        end else begin
            case (code_c)
                3'b000:  cmd_c = CMD_MRS;
                3'b001:  cmd_c = CMD_REF;
                3'b010:  cmd_c = A[A10_BIT] ? CMD_PREA : CMD_PRE;
                3'b100:  cmd_c = CMD_WR;
                3'b101:  cmd_c = CMD_RD;
                3'b110:  cmd_c = CMD_ZQC;
                default: cmd_c = CMD_NOP;
            endcase
        end
        cmd_oh_c = any_sel_c ? cmd_onehot(cmd_c) : '0;
    end

    for (genvar r = 0; r < int'(RANKS); r++) begin : g_rank
        for (genvar g = 0; g < int'(BANKGROUPS); g++) begin : g_group
            for (genvar b = 0; b < int'(BANKSPERGROUP); b++) begin : g_bank
                bank_req_t req_c;
                logic      hit_c;

                // Route the decoded command to this bank
                always_comb begin
                    hit_c       = (bg == BGWIDTH'(g)) && (ba == BAWIDTH'(b));
                    req_c       = '0;
                    req_c.act   = sel_c[r] && (cmd_c == CMD_ACT) && hit_c;
                    req_c.pre   = sel_c[r] && (((cmd_c == CMD_PRE) && hit_c) ||
                                               (cmd_c == CMD_PREA));
                    req_c.rw    = sel_c[r] && ((cmd_c == CMD_WR) || (cmd_c == CMD_RD)) && hit_c;
                    req_c.wr    = (cmd_c == CMD_WR);
                    req_c.bc4   = bc4_c;
                end

                bank_burst_ctrl #(
                    .ADDRWIDTH (ADDRWIDTH),
                    .COLWIDTH  (COLWIDTH),
                    .BL        (BL)
                ) u_bank (
                    .clk       (clk),
                    .rst_n     (reset_n),
                    .cke       (cke),
                    .req_i     (req_c),
                    .addr_i    (A),
                    .row_o     (RowId[r][g][b]),
                    .col_o     (ColId[r][g][b]),
                    .wr_o      (rd_o_wr[r][g][b]),
                    .burst_o   (Burst[r][g][b]),
                    .open_o    (BankOpen[r][g][b]),
                    .illegal_c (bank_ill_c[r][g][b])
                );
            end
        end
    end

    // Per-rank violation: any bank violation, or REF with a bank open
    always_comb begin
        ill_c = '0;
        for (int r = 0; r < int'(RANKS); r++) begin
            for (int g = 0; g < int'(BANKGROUPS); g++) begin
                for (int b = 0; b < int'(BANKSPERGROUP); b++) begin
                    ill_c[r] = ill_c[r] | bank_ill_c[r][g][b] |
                               (sel_c[r] && (cmd_c == CMD_REF) && BankOpen[r][g][b]);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            commands <= '0;
            illegal  <= '0;
        end else begin
            commands <= cmd_oh_c;
            illegal  <= ill_c;
        end
    end

endmodule
